// File: rtl/sdram_bridge_pkg.sv
// Shared types and widths for the northbridge-to-Avalon SDRAM bridge.
package sdram_bridge_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } sdram_cmd_t;

    localparam int CMD_W = $bits(sdram_cmd_t);

endpackage

// File: rtl/sdram_bridge_if.sv
// Bus bundles for the bridge: northbridge request/return port and Avalon-MM master port.
interface sdram_nb_if;
    import sdram_bridge_pkg::*;

    logic [ADDR_W-1:0] az_addr;
    logic [BE_W-1:0]   az_be_n;
    logic [DATA_W-1:0] az_data;
    logic              az_rd_n;
    logic              az_wr_n;
    logic [DATA_W-1:0] za_data;
    logic              za_valid;
    logic              za_waitrequest;

    modport master (
        output az_addr, az_be_n, az_data, az_rd_n, az_wr_n,
        input  za_data, za_valid, za_waitrequest
    );

    modport slave (
        input  az_addr, az_be_n, az_data, az_rd_n, az_wr_n,
        output za_data, za_valid, za_waitrequest
    );
endinterface

interface sdram_avm_if;
    import sdram_bridge_pkg::*;

    logic [ADDR_W-1:0] avm_address;
    logic [BE_W-1:0]   avm_byteenable;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_read;
    logic              avm_write;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address, avm_byteenable, avm_writedata, avm_read, avm_write,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_writedata, avm_read, avm_write,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/sdram_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO; o_head is the oldest entry whenever o_empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_bridge.sv
// Posts northbridge strobes into a command FIFO, drives them as held Avalon requests,
// and returns read data as a registered single-cycle pulse.
module sdram_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RD     = 2
) (
    input  logic       clk,
    input  logic       reset,
    sdram_nb_if.slave  nb,
    sdram_avm_if.master avm,
    output logic       proto_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int RD_W  = $clog2(MAX_RD + 1);

    logic             w_rd_strobe;
    logic             w_wr_strobe;
    logic             w_both_strobe;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    sdram_cmd_t       w_push_cmd;
    sdram_cmd_t       w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_rd_gated;
    logic             w_avm_read;
    logic             w_avm_write;
    logic             w_rd_accept;
    logic             w_rd_return;
    logic             w_stray_rdv;

    logic [RD_W-1:0]   r_rd_out;
    logic              r_proto_err;
    logic              r_za_valid;
    logic [DATA_W-1:0] r_za_data;

    assign w_rd_strobe   = !nb.az_rd_n &&  nb.az_wr_n;
    assign w_wr_strobe   =  nb.az_rd_n && !nb.az_wr_n;
    assign w_both_strobe = !nb.az_rd_n && !nb.az_wr_n;
    assign w_push_req    = w_rd_strobe || w_wr_strobe;
    assign w_push        = w_push_req && !w_full;
    assign w_push_cmd    = {w_wr_strobe, nb.az_addr, ~nb.az_be_n, nb.az_data};

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A read head stalls at the outstanding limit, and because it stays at the
    // head nothing behind it can overtake.
    assign w_rd_gated  = (r_rd_out == RD_W'(MAX_RD));
    assign w_avm_read  = !w_empty && !w_head.we && !w_rd_gated;
    assign w_avm_write = !w_empty &&  w_head.we;
    assign w_pop       = (w_avm_read || w_avm_write) && !avm.avm_waitrequest;
    assign w_rd_accept = w_avm_read && !avm.avm_waitrequest;
    assign w_rd_return = avm.avm_readdatavalid && (r_rd_out != '0);
    assign w_stray_rdv = avm.avm_readdatavalid && (r_rd_out == '0);

    assign avm.avm_read       = w_avm_read;
    assign avm.avm_write      = w_avm_write;
    assign avm.avm_address    = w_empty ? '0 : w_head.addr;
    assign avm.avm_byteenable = w_empty ? '0 : w_head.be;
    assign avm.avm_writedata  = w_empty ? '0 : w_head.data;

    // One entry of slack absorbs the strobe the northbridge registers before it
    // sees waitrequest rise.
    assign nb.za_waitrequest = (w_count >= CNT_W'(FIFO_DEPTH - 1));
    assign nb.za_valid       = r_za_valid;
    assign nb.za_data        = r_za_data;
    assign proto_err         = r_proto_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_out <= '0;
        end else begin
            case ({w_rd_accept, w_rd_return})
                2'b10:   r_rd_out <= r_rd_out + 1'b1;
                2'b01:   r_rd_out <= r_rd_out - 1'b1;
                default: r_rd_out <= r_rd_out;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (w_both_strobe || (w_push_req && w_full) || w_stray_rdv) begin
            r_proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_za_valid <= 1'b0;
            r_za_data  <= '0;
        end else begin
            r_za_valid <= w_rd_return;
            if (w_rd_return) begin
                r_za_data <= avm.avm_readdata;
            end
        end
    end

endmodule

// File: tb/tb_sdram_bridge.sv
// Directed scoreboard bench for sdram_bridge: expected Avalon commands and read returns are
// queued by the stimulus and popped by a negedge monitor.
module tb_sdram_bridge;
    import sdram_bridge_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic proto_err;

    always #5 clk = ~clk;

    sdram_nb_if  nb_if ();
    sdram_avm_if avm_if ();

    sdram_bridge #(
        .FIFO_DEPTH (4),
        .MAX_RD     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .nb        (nb_if),
        .avm       (avm_if),
        .proto_err (proto_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [40:0] exp_cmd_q [$];
    logic [15:0] exp_rd_q  [$];

    logic        prev_stall = 1'b0;
    logic [41:0] prev_bus   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: an asserted request with waitrequest low is accepted at the next edge.
    always @(negedge clk) begin
        logic [41:0] cur_bus;
        cur_bus = {avm_if.avm_read, avm_if.avm_write, avm_if.avm_address,
                   avm_if.avm_byteenable, avm_if.avm_writedata};
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("avm_hold_stable", cur_bus, prev_bus);
            if ((avm_if.avm_read || avm_if.avm_write) && !avm_if.avm_waitrequest) begin
                if (exp_cmd_q.size() == 0) check("avm_unexpected_cmd", 64'(cur_bus), 64'h0);
                else check("avm_cmd", 64'(cur_bus[40:0]), 64'(exp_cmd_q.pop_front()));
            end
            prev_stall = (avm_if.avm_read || avm_if.avm_write) && avm_if.avm_waitrequest;
            prev_bus   = cur_bus;
            if (nb_if.za_valid) begin
                if (exp_rd_q.size() == 0) check("za_unexpected_valid", 64'(nb_if.za_data), 64'hFFFF_FFFF);
                else check("za_data", 64'(nb_if.za_data), 64'(exp_rd_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [21:0] a, input logic [1:0] ben, input logic [15:0] d, input bit exp_en);
        nb_if.az_wr_n = 1'b0;
        nb_if.az_addr = a;
        nb_if.az_be_n = ben;
        nb_if.az_data = d;
        if (exp_en) exp_cmd_q.push_back({1'b1, a, ~ben, d});
        tick();
        nb_if.az_wr_n = 1'b1;
    endtask

    task automatic rd(input logic [21:0] a, input bit exp_en);
        nb_if.az_rd_n = 1'b0;
        nb_if.az_addr = a;
        nb_if.az_be_n = 2'b00;
        nb_if.az_data = 16'h0000;
        if (exp_en) exp_cmd_q.push_back({1'b0, a, 2'b11, 16'h0000});
        tick();
        nb_if.az_rd_n = 1'b1;
    endtask

    task automatic rdv(input logic [15:0] d, input bit exp_en);
        avm_if.avm_readdatavalid = 1'b1;
        avm_if.avm_readdata      = d;
        if (exp_en) exp_rd_q.push_back(d);
        tick();
        avm_if.avm_readdatavalid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avm_read"},  64'(avm_if.avm_read), 64'h0);
        check({tag, "_avm_write"}, 64'(avm_if.avm_write), 64'h0);
        check({tag, "_avm_addr"},  64'(avm_if.avm_address), 64'h0);
        check({tag, "_avm_be"},    64'(avm_if.avm_byteenable), 64'h0);
        check({tag, "_avm_wdata"}, 64'(avm_if.avm_writedata), 64'h0);
        check({tag, "_za_valid"},  64'(nb_if.za_valid), 64'h0);
        check({tag, "_za_data"},   64'(nb_if.za_data), 64'h0);
        check({tag, "_za_wait"},   64'(nb_if.za_waitrequest), 64'h0);
        check({tag, "_proto_err"}, 64'(proto_err), 64'h0);
    endtask

    // Reset spans a negedge so the monitor drops any in-progress hold tracking.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                    = 1'b1;
        nb_if.az_rd_n            = 1'b1;
        nb_if.az_wr_n            = 1'b1;
        nb_if.az_addr            = '0;
        nb_if.az_be_n            = 2'b11;
        nb_if.az_data            = '0;
        avm_if.avm_waitrequest   = 1'b0;
        avm_if.avm_readdata      = '0;
        avm_if.avm_readdatavalid = 1'b0;

        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single write, no stall
        wr(22'h012345, 2'b10, 16'hBEEF, 1'b1);
        @(negedge clk);
        check("t1_write", 64'(avm_if.avm_write), 64'h1);
        check("t1_be",    64'(avm_if.avm_byteenable), 64'h1);
        check("t1_addr",  64'(avm_if.avm_address), 64'h012345);
        check("t1_data",  64'(avm_if.avm_writedata), 64'hBEEF);
        tick();
        @(negedge clk);
        check("t1_empty", 64'(avm_if.avm_write | avm_if.avm_read), 64'h0);

        // Read held by waitrequest for 3 cycles
        avm_if.avm_waitrequest = 1'b1;
        rd(22'h000010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_read_held", 64'(avm_if.avm_read), 64'h1);
            check("t2_addr",      64'(avm_if.avm_address), 64'h10);
            tick();
        end
        avm_if.avm_waitrequest = 1'b0;
        @(negedge clk);
        check("t2_read_last", 64'(avm_if.avm_read), 64'h1);
        tick();
        @(negedge clk);
        check("t2_read_done", 64'(avm_if.avm_read), 64'h0);
        tick();
        rdv(16'hA5A5, 1'b1);
        @(negedge clk);
        check("t2_za_valid", 64'(nb_if.za_valid), 64'h1);
        check("t2_za_data",  64'(nb_if.za_data), 64'hA5A5);
        tick();
        @(negedge clk);
        check("t2_za_pulse", 64'(nb_if.za_valid), 64'h0);
        check("t2_za_hold",  64'(nb_if.za_data), 64'hA5A5);

        // FIFO fill with the slave stuck busy
        avm_if.avm_waitrequest = 1'b1;
        wr(22'h000100, 2'b00, 16'h1111, 1'b1);
        wr(22'h000101, 2'b01, 16'h2222, 1'b1);
        @(negedge clk);
        check("t3_wait_at2", 64'(nb_if.za_waitrequest), 64'h0);
        wr(22'h000102, 2'b10, 16'h3333, 1'b1);
        @(negedge clk);
        check("t3_wait_at3", 64'(nb_if.za_waitrequest), 64'h1);
        wr(22'h000103, 2'b11, 16'h4444, 1'b1);
        @(negedge clk);
        check("t3_err_at4", 64'(proto_err), 64'h0);
        wr(22'h000104, 2'b00, 16'h5555, 1'b0);
        @(negedge clk);
        check("t3_err_drop", 64'(proto_err), 64'h1);
        check("t3_wait_full", 64'(nb_if.za_waitrequest), 64'h1);
        avm_if.avm_waitrequest = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("t3_drained", 64'(avm_if.avm_write), 64'h0);
        check("t3_queue",   64'(exp_cmd_q.size()), 64'h0);
        check("t3_wait_low", 64'(nb_if.za_waitrequest), 64'h0);
        do_reset("rst1");

        // Read gating at the outstanding limit
        rd(22'h000200, 1'b1);
        rd(22'h000201, 1'b1);
        rd(22'h000202, 1'b1);
        @(negedge clk);
        check("t4_gated",     64'(avm_if.avm_read), 64'h0);
        check("t4_head_addr", 64'(avm_if.avm_address), 64'h202);
        tick();
        @(negedge clk);
        check("t4_still_gated", 64'(avm_if.avm_read), 64'h0);
        rdv(16'h0A01, 1'b1);
        @(negedge clk);
        check("t4_released", 64'(avm_if.avm_read), 64'h1);
        tick();
        rdv(16'h0A02, 1'b1);
        rdv(16'h0A03, 1'b1);
        tick();
        @(negedge clk);
        check("t4_rd_queue", 64'(exp_rd_q.size()), 64'h0);
        do_reset("rst2");

        // Both strobes low
        nb_if.az_rd_n = 1'b0;
        nb_if.az_wr_n = 1'b0;
        tick();
        nb_if.az_rd_n = 1'b1;
        nb_if.az_wr_n = 1'b1;
        @(negedge clk);
        check("t5_both_err", 64'(proto_err), 64'h1);
        check("t5_no_push",  64'(avm_if.avm_read | avm_if.avm_write), 64'h0);
        do_reset("rst3");

        // Stray readdatavalid
        rdv(16'hDEAD, 1'b0);
        @(negedge clk);
        check("t5_stray_err",   64'(proto_err), 64'h1);
        check("t5_stray_valid", 64'(nb_if.za_valid), 64'h0);
        check("t5_stray_data",  64'(nb_if.za_data), 64'h0);

        // Reset with one read outstanding and two commands queued
        do_reset("rst4");
        rd(22'h000300, 1'b1);
        tick();
        avm_if.avm_waitrequest = 1'b1;
        wr(22'h000301, 2'b00, 16'h6666, 1'b0);
        wr(22'h000302, 2'b00, 16'h7777, 1'b0);
        @(negedge clk);
        check("t6_queued", 64'(avm_if.avm_write), 64'h1);
        do_reset("t6_rst");
        avm_if.avm_waitrequest = 1'b0;
        @(negedge clk);
        check("t6_empty", 64'(avm_if.avm_read | avm_if.avm_write), 64'h0);
        rdv(16'hBEAD, 1'b0);
        @(negedge clk);
        check("t6_stray_err",   64'(proto_err), 64'h1);
        check("t6_stray_valid", 64'(nb_if.za_valid), 64'h0);

        tick();
        check("end_cmd_queue", 64'(exp_cmd_q.size()), 64'h0);
        check("end_rd_queue",  64'(exp_rd_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_bridge.md
# sdram_bridge

Sits between the northbridge's SDRAM request port (`az_*` / `za_*`) and the Avalon-MM SDRAM controller. It turns the northbridge's one-clock active-low read/write strobes into held Avalon requests that respect `avm_waitrequest`, and queues commands in a small FIFO so writes are posted. It tracks outstanding reads and returns read data to the northbridge as a single-cycle `za_valid` pulse.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥ 2.
- `MAX_RD`, 2: maximum reads outstanding at the Avalon slave; ≥ 1.

- `clk` in 1: system clock, same clock as the northbridge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `az_addr` in 22: word address.
- `az_be_n` in 2: byte enables, active-low, {high, low}.
- `az_data` in 16: write data.
- `az_rd_n` in 1: read strobe, active-low, one clock wide.
- `az_wr_n` in 1: write strobe, active-low, one clock wide.
- `za_data` out 16: read data returned to the northbridge.
- `za_valid` out 1: one-cycle pulse; `za_data` is valid in that cycle.
- `za_waitrequest` out 1: high means the northbridge must not issue a strobe.
- `avm_address` out 22: Avalon word address.
- `avm_byteenable` out 2: Avalon byte enables, active-high (`~az_be_n`).
- `avm_writedata` out 16: Avalon write data.
- `avm_read` out 1: Avalon read request.
- `avm_write` out 1: Avalon write request.
- `avm_waitrequest` in 1: Avalon slave stall.
- `avm_readdata` in 16: Avalon read data.
- `avm_readdatavalid` in 1: Avalon read data valid.
- `proto_err` out 1: sticky error flag; cleared only by `reset`.

## Operation
- **Push.** Any cycle with exactly one of `az_rd_n`/`az_wr_n` low pushes {we, addr, ~be_n, data} into the FIFO.
  - Both strobes low: no push, set `proto_err`.
  - Push while the FIFO is full: command dropped, set `proto_err`.
- **Flow control to the northbridge.** `za_waitrequest = (count >= FIFO_DEPTH-1)`. This covers the one-clock lag between the northbridge sampling waitrequest and issuing its registered strobe.
- **Head presentation.** While the FIFO is non-empty, the head entry drives `avm_address`, `avm_byteenable` and `avm_writedata`. It also raises `avm_write` if `we`, or `avm_read` if `!we`.
  - A read head is gated: `avm_read` stays 0 while `rd_out == MAX_RD`.
  - A gated read head also blocks all later commands, so ordering is strictly preserved.
- **Accept/pop.** A request is accepted on a rising edge where it is asserted and `avm_waitrequest == 0`; the FIFO pops on acceptance.
  - While `avm_waitrequest` is high, address, data, byteenable and request stay stable.
- **Outstanding-read counter `rd_out`** (0..MAX_RD):
  - +1 on read accept, −1 on `avm_readdatavalid`; both in the same cycle gives no change.
  - `avm_readdatavalid` with `rd_out == 0`: ignored, set `proto_err`.
- **Return path.** `za_data <= avm_readdata` and `za_valid <= avm_readdatavalid` (registered). `za_valid` is a pulse; `za_data` holds its last value otherwise.
- **Simultaneous push and pop:** `count` is unchanged. Pushing to an empty FIFO makes the entry the head in the next cycle.

## Timing
- **Reset values:** FIFO empty, `count = 0`, `rd_out = 0`, all `avm_*` requests 0, `avm_address`/`avm_byteenable`/`avm_writedata` 0, `za_valid = 0`, `za_data = 0`, `za_waitrequest = 0`, `proto_err = 0`.
- **Reset mid-operation:** queued commands and outstanding reads are discarded. `avm_readdatavalid` arriving after reset is treated as an error.
- **Latency:** strobe in cycle N → `avm_read`/`avm_write` high in cycle N+1 if the FIFO was empty and the read is not gated.
  - With no waitrequest, the request is accepted at the end of N+1.
- **Read return:** `avm_readdatavalid` in cycle M → `za_valid` in cycle M+1.
- **Throughput:** one Avalon command per clock when there is no waitrequest and no gating.

## Structure
- **Package `sdram_bridge_pkg`:**
  - command struct `sdram_cmd_t` {we:1, addr:22, be:2, data:16} = 41 bits;
  - address and data width constants;
  - `ADDR_W = 22`, `DATA_W = 16`.
- **Sub-module `sync_fifo`**, parameterised on width and depth. It provides push/pop, full/empty, count, and a head output that is valid while non-empty (show-ahead). It has an asynchronous active-high reset.
- **Top level:** strobe decode, `za_waitrequest`, read gating, `rd_out`, `proto_err`, return register.

## Test plan
- **Single write, no stall:** `az_wr_n` low in cycle 0 with addr 0x012345, data 0xBEEF, be_n 2'b10 → `avm_write = 1` in cycle 1 with byteenable 2'b01 and the same addr/data; FIFO empty in cycle 2; `za_valid` never asserts.
- **Read with waitrequest:** read of addr 0x000010 while `avm_waitrequest` is high for 3 cycles → `avm_read` held 4 cycles with a stable address. Slave returns 0xA5A5 with `readdatavalid` 2 cycles later → `za_valid` one cycle, `za_data = 0xA5A5`.
- **FIFO fill:** `avm_waitrequest` stuck high, 3 write strobes with DEPTH = 4 → `za_waitrequest` rises after the 3rd push. A 4th strobe is accepted (count = 4); a 5th strobe is dropped and sets `proto_err`.
- **Read gating:** MAX_RD = 2, 3 back-to-back reads, no `readdatavalid` → 2 accepted and the third held with `avm_read = 0`. The first `readdatavalid` → third `avm_read` asserts the next cycle.
- **Errors:** both strobes low → no push, `proto_err = 1`. Stray `avm_readdatavalid` with `rd_out = 0` → `proto_err = 1`, no `za_valid`.
- **Reset mid-flight:** assert `reset` with 2 queued commands and 1 read outstanding → all outputs return to reset values in the same cycle, and the FIFO is empty after deassertion.
